// File: rtl/lamp_pkg.sv
// Shared constants and state encoding for the lamp-state encoder.
// Lamp count, code width and saturation value live here.
package lamp_pkg;
   localparam int N_LAMPS = 16;
   localparam int CODE_W  = 4;
   localparam int IDX_W   = $clog2(N_LAMPS);
   localparam int CNT_W   = $clog2(N_LAMPS + 1);

   localparam logic [CODE_W-1:0] CODE_MAX = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_SCAN,
      ST_DONE
   } state_t;
endpackage

// File: rtl/lamp_state_encoder_if.sv
// Controller-facing bundle of the lamp-state encoder.
// master = controller/lamp side, slave = encoder.
interface lamp_state_encoder_if
   import lamp_pkg::*;
   ;
   logic [N_LAMPS-1:0] lights_state;
   logic               start;
   logic               busy;
   logic               done;
   logic [CODE_W-1:0]  active_lights;
   logic               count_ovf;
   logic               not_thermo;

   modport master (
      output lights_state, start,
      input  busy, done, active_lights, count_ovf, not_thermo
   );

   modport slave (
      input  lights_state, start,
      output busy, done, active_lights, count_ovf, not_thermo
   );
endinterface

// File: rtl/lamp_debounce.sv
// Snapshot register with a stability counter; stable rises once the
// input has matched the snapshot for DEBOUNCE_CYC consecutive edges.
module lamp_debounce
   import lamp_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic [N_LAMPS-1:0] din,
   output logic [N_LAMPS-1:0] snap,
   output logic               stable
);
   localparam int SW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE_CYC - 1);

   logic [SW-1:0] stab;
   logic          same;

   assign same   = (din == snap);
   assign stable = same && (stab == STAB_LAST);

   // Counter saturates so a held snapshot never wraps back to unstable.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap <= '0;
         stab <= '0;
      end else if (clr || !same) begin
         snap <= din;
         stab <= '0;
      end else if (stab != STAB_LAST) begin
         stab <= stab + SW'(1);
      end
   end
endmodule

// File: rtl/lamp_state_encoder.sv
// Debounces the lamp feedback bus, then scans the snapshot serially to
// recover the lit-lamp count, saturation and thermometer-error flags.
module lamp_state_encoder
   import lamp_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   lamp_state_encoder_if.slave  bus
);
   state_t             state;
   state_t             state_nx;
   logic [N_LAMPS-1:0] snap;
   logic [N_LAMPS-1:0] din;
   logic               stable;
   logic               clr;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nx;
   logic               seen_zero;
   logic               thermo_err;
   logic               terr_nx;
   logic               bit_cur;
   logic               last;
   logic               ovf_nx;
   logic [CODE_W-1:0]  code_q;
   logic               ovf_q;
   logic               nt_q;

   assign clr = (state == ST_IDLE) && bus.start;

   // Outside SAMPLE the debouncer sees its own snapshot, freezing it.
   assign din = (state == ST_SAMPLE || clr) ? bus.lights_state : snap;

   lamp_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .din    (din),
      .snap   (snap),
      .stable (stable)
   );

   assign bit_cur = snap[idx];
   assign last    = (idx == IDX_W'(N_LAMPS - 1));
   assign cnt_nx  = cnt + CNT_W'(bit_cur);
   assign terr_nx = thermo_err | (bit_cur & seen_zero);
   assign ovf_nx  = (cnt_nx == CNT_W'(N_LAMPS));

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   if (bus.start) state_nx = ST_SAMPLE;
         ST_SAMPLE: if (stable)    state_nx = ST_SCAN;
         ST_SCAN:   if (last)      state_nx = ST_DONE;
         ST_DONE:                  state_nx = ST_IDLE;
         default:                  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         cnt        <= '0;
         seen_zero  <= 1'b0;
         thermo_err <= 1'b0;
         code_q     <= '0;
         ovf_q      <= 1'b0;
         nt_q       <= 1'b0;
      end else if (state == ST_SAMPLE && stable) begin
         idx        <= '0;
         cnt        <= '0;
         seen_zero  <= 1'b0;
         thermo_err <= 1'b0;
      end else if (state == ST_SCAN) begin
         idx        <= idx + IDX_W'(1);
         cnt        <= cnt_nx;
         seen_zero  <= seen_zero | ~bit_cur;
         thermo_err <= terr_nx;
         if (last) begin
            code_q <= ovf_nx ? CODE_MAX : cnt_nx[CODE_W-1:0];
            ovf_q  <= ovf_nx;
            nt_q   <= terr_nx;
         end
      end
   end

   assign bus.busy          = (state != ST_IDLE);
   assign bus.done          = (state == ST_DONE);
   assign bus.active_lights = code_q;
   assign bus.count_ovf     = ovf_q;
   assign bus.not_thermo    = nt_q;
endmodule

// File: tb/tb_lamp_state_encoder.sv
// Directed bench for lamp_state_encoder: latency, codes, flags,
// debounce restarts, busy-time start/input changes and reset abort.
module tb_lamp_state_encoder;
   import lamp_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   lamp_state_encoder_if bus ();

   lamp_state_encoder #(
      .DEBOUNCE_CYC (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start(input logic [15:0] v, output int lat);
      @(negedge clk);
      bus.lights_state = v;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 1;
   endtask

   task automatic wait_done(inout int lat);
      bit ok;
      ok = 1'b0;
      while (lat < 200 && !ok) begin
         @(negedge clk);
         if (bus.done) ok = 1'b1;
         else begin
            @(posedge clk);
            lat++;
         end
      end
      if (!ok) check("done_timeout", 32'(lat), 32'd0);
   endtask

   task automatic check_res(input string tag, input logic [3:0] code,
                            input logic ovf, input logic nt);
      check({tag, "_code"}, 32'(bus.active_lights), 32'(code));
      check({tag, "_ovf"}, 32'(bus.count_ovf), 32'(ovf));
      check({tag, "_nt"}, 32'(bus.not_thermo), 32'(nt));
   endtask

   typedef struct {
      logic [15:0] v;
      logic [3:0]  code;
      logic        ovf;
      logic        nt;
   } vec_t;

   vec_t vecs[7] = '{
      '{16'h0000, 4'd0,  1'b0, 1'b0},
      '{16'h03FF, 4'd10, 1'b0, 1'b0},
      '{16'hFFFF, 4'd15, 1'b1, 1'b0},
      '{16'h0005, 4'd2,  1'b0, 1'b1},
      '{16'h8000, 4'd1,  1'b0, 1'b1},
      '{16'h7FFF, 4'd15, 1'b0, 1'b0},
      '{16'hFFFE, 4'd15, 1'b0, 1'b1}
   };

   initial begin
      int lat;
      int lat2;
      int ndone;
      logic [16:0] t;

      bus.lights_state = '0;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check_res("rst", 4'd0, 1'b0, 1'b0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         pulse_start(vecs[i].v, lat);
         wait_done(lat);
         check($sformatf("lat_%04h", vecs[i].v), 32'(lat), 32'd21);
         check_res($sformatf("v_%04h", vecs[i].v),
                   vecs[i].code, vecs[i].ovf, vecs[i].nt);
      end

      for (int k = 0; k < 16; k++) begin
         t = (17'd1 << k) - 17'd1;
         pulse_start(t[15:0], lat);
         wait_done(lat);
         check_res($sformatf("rt_%0d", k), 4'(k), 1'b0, 1'b0);
      end

      // two toggles during SAMPLE push the scan back two cycles
      pulse_start(16'h00FF, lat);
      bus.lights_state = 16'h01FF;
      @(posedge clk);
      lat++;
      #1;
      bus.lights_state = 16'h00FF;
      wait_done(lat);
      check("tog_lat", 32'(lat), 32'd23);
      check_res("tog", 4'd8, 1'b0, 1'b0);

      // start while busy and input churn during SCAN
      pulse_start(16'h000F, lat);
      repeat (2) begin
         @(posedge clk);
         lat++;
      end
      #1;
      bus.start = 1'b1;
      @(posedge clk);
      lat++;
      #1;
      bus.start = 1'b0;
      repeat (6) begin
         @(posedge clk);
         lat++;
      end
      #1;
      bus.lights_state = 16'hFFFF;
      bus.start = 1'b1;
      @(posedge clk);
      lat++;
      #1;
      bus.start = 1'b0;
      bus.lights_state = 16'h5555;
      wait_done(lat);
      check("busy_lat", 32'(lat), 32'd21);
      check_res("busy", 4'd4, 1'b0, 1'b0);
      @(negedge clk);
      check("done_pulse", 32'(bus.done), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      ndone = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("extra_done", 32'(ndone), 32'd0);

      // start held high: back-to-back encodes
      @(negedge clk);
      bus.lights_state = 16'h0001;
      bus.start = 1'b1;
      @(posedge clk);
      lat = 1;
      wait_done(lat);
      check("b2b_lat1", 32'(lat), 32'd21);
      @(posedge clk);
      lat2 = 1;
      wait_done(lat2);
      bus.start = 1'b0;
      check("b2b_gap", 32'(lat2), 32'd22);
      check_res("b2b", 4'd1, 1'b0, 1'b0);

      // reset mid-SCAN aborts and clears
      pulse_start(16'hFFFF, lat);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check_res("abort", 4'd0, 1'b0, 1'b0);
      rst = 1'b0;
      pulse_start(16'h0007, lat);
      wait_done(lat);
      check("post_lat", 32'(lat), 32'd21);
      check_res("post", 4'd3, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
